// File: rtl/subleq_pkg.sv
// subleq_pkg
//   Shared definitions for the SUBLEQ core: controller state encoding and
//   default datapath widths used as parameter defaults by the core and its
//   subtractor.
package subleq_pkg;

    localparam int unsigned STATE_W      = 4;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_COUNT_W  = 32;
    localparam int unsigned DEF_RESET_PC = 0;

    // FA/FB/FC fetch the three operand words, RA/RB read the two data
    // words, WB writes the difference back, BR resolves the branch.
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 4'd0,
        FA     = 4'd1,
        FB     = 4'd2,
        FC     = 4'd3,
        RA     = 4'd4,
        RB     = 4'd5,
        WB     = 4'd6,
        BR     = 4'd7,
        PAUSE  = 4'd8,
        HALTED = 4'd9
    } state_t;

endpackage

// File: rtl/subleq_sub_unit.sv
// subleq_sub_unit
//   Combinational SUBLEQ ALU: diff = mb - ma (mod 2^DATA_W) with zero and
//   negative (MSB) detection.
//   Ports:
//     mb, ma  in   DATA_W  minuend / subtrahend
//     diff    out  DATA_W  mb - ma
//     zero    out  1       diff == 0
//     neg     out  1       diff MSB
module subleq_sub_unit
    import subleq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
)(
    input  logic [DATA_W-1:0] mb,
    input  logic [DATA_W-1:0] ma,
    output logic [DATA_W-1:0] diff,
    output logic              zero,
    output logic              neg
);

    always_comb begin
        diff = mb - ma;
        zero = (diff == '0);
        neg  = diff[DATA_W-1];
    end

endmodule

// File: rtl/subleq_core.sv
// subleq_core
//   SUBLEQ processor core: PC/operand/MDR registers, control FSM and a
//   req/ack memory port tolerant of any memory latency. Adds halt
//   detection, single-step mode and a retired-instruction counter.
//   Ports:
//     clk, reset          clock; asynchronous active-high reset
//     start               pulse: from IDLE/HALTED load PC=RESET_PC and run
//     step_mode, step     pause after each instruction; step releases it
//     mem_req/we/addr/wdata/rdata/ack   memory handshake
//     pc                  current PC
//     flag_z, flag_n      registered zero/negative of last result
//     busy, halted        status (busy = not IDLE and not HALTED)
//     instr_count         retired instructions, wraps at 2^COUNT_W
module subleq_core
    import subleq_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned COUNT_W  = DEF_COUNT_W
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic [ADDR_W-1:0]  pc,
    output logic               flag_z,
    output logic               flag_n,
    output logic               busy,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   a_q;
    logic [ADDR_W-1:0]   b_q;
    logic [DATA_W-1:0]   c_q;
    logic [DATA_W-1:0]   ma_q;
    logic [DATA_W-1:0]   mb_q;
    logic [COUNT_W-1:0]  count_q;
    logic [DATA_W-1:0]   diff;
    logic                diff_zero;
    logic                diff_neg;
    logic                taken;
    logic                halt_br;

    subleq_sub_unit #(
        .DATA_W (DATA_W)
    ) u_sub (
        .mb   (mb_q),
        .ma   (ma_q),
        .diff (diff),
        .zero (diff_zero),
        .neg  (diff_neg)
    );

    // Flags were captured at the WB ack, so BR sees this instruction's result.
    always_comb begin
        taken   = flag_z | flag_n;
        halt_br = taken & c_q[DATA_W-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = FA;
            FA:     if (mem_ack) state_nx = FB;
            FB:     if (mem_ack) state_nx = FC;
            FC:     if (mem_ack) state_nx = RA;
            RA:     if (mem_ack) state_nx = RB;
            RB:     if (mem_ack) state_nx = WB;
            WB:     if (mem_ack) state_nx = BR;
            BR: begin
                if (halt_br)        state_nx = HALTED;
                else if (step_mode) state_nx = PAUSE;
                else                state_nx = FA;
            end
            PAUSE:  if (step || !step_mode) state_nx = FA;
            HALTED: if (start) state_nx = FA;
            default: state_nx = IDLE;
        endcase
    end

    // Memory port is a pure function of state and registers, so it is
    // stable for as long as the FSM waits for ack and drops with reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            FA: begin mem_req = 1'b1; mem_addr = pc_q; end
            FB: begin mem_req = 1'b1; mem_addr = pc_q + ADDR_W'(1); end
            FC: begin mem_req = 1'b1; mem_addr = pc_q + ADDR_W'(2); end
            RA: begin mem_req = 1'b1; mem_addr = a_q; end
            RB: begin mem_req = 1'b1; mem_addr = b_q; end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = b_q;
                mem_wdata = diff;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE, HALTED: if (start) pc_q <= ADDR_W'(RESET_PC);
                FA: if (mem_ack) a_q  <= mem_rdata[ADDR_W-1:0];
                FB: if (mem_ack) b_q  <= mem_rdata[ADDR_W-1:0];
                FC: if (mem_ack) c_q  <= mem_rdata;
                RA: if (mem_ack) ma_q <= mem_rdata;
                RB: if (mem_ack) mb_q <= mem_rdata;
                WB: if (mem_ack) begin
                    flag_z <= diff_zero;
                    flag_n <= diff_neg;
                end
                BR: begin
                    count_q <= count_q + COUNT_W'(1);
                    if (!taken)       pc_q <= pc_q + ADDR_W'(3);
                    else if (!halt_br) pc_q <= c_q[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pc          = pc_q;
        instr_count = count_q;
        busy        = (state != IDLE) && (state != HALTED);
        halted      = (state == HALTED);
    end

endmodule

// File: tb/tb_subleq_core.sv
// tb_subleq_core
//   Directed bench for subleq_core with a behavioural memory that answers
//   the req/ack port with a programmable number of wait states.
module tb_subleq_core;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned COUNT_W = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               step_mode = 1'b0;
    logic               step = 1'b0;
    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata = '0;
    logic               mem_ack = 1'b0;
    logic [ADDR_W-1:0]  pc;
    logic               flag_z;
    logic               flag_n;
    logic               busy;
    logic               halted;
    logic [COUNT_W-1:0] instr_count;

    logic [DATA_W-1:0]  mem [0:65535];
    int unsigned        lat = 0;
    logic               ack_block = 1'b0;
    int unsigned        wait_cnt = 0;
    logic [ADDR_W-1:0]  hold_addr;
    logic               hold_we;
    logic [DATA_W-1:0]  hold_wdata;

    int unsigned        n_vec = 0;
    int unsigned        n_miss = 0;

    subleq_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (0),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .pc          (pc),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder: ack is decided at the falling edge, so the core
    // latches rdata at the following rising edge.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wait_cnt == 0) begin
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
            end else begin
                check_val("hold_addr",  32'(mem_addr),  32'(hold_addr));
                check_val("hold_we",    32'(mem_we),    32'(hold_we));
                check_val("hold_wdata", 32'(mem_wdata), 32'(hold_wdata));
            end
            if (!ack_block && wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_step;
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Instruction 0: mem[11] -= mem[10] (5 -> 7 gives 2), continue at 3.
    // Instruction 3: mem[10] -= mem[10] gives 0, taken to C=FFFF -> halt.
    task automatic load_prog1;
        mem[0]  = 16'd10; mem[1] = 16'd11; mem[2] = 16'd3;
        mem[3]  = 16'd10; mem[4] = 16'd10; mem[5] = 16'hFFFF;
        mem[10] = 16'd5;
        mem[11] = 16'd7;
    endtask

    task automatic wait_halt(input string tag);
        int unsigned i;
        i = 0;
        while (!halted && i < 200) begin
            tick(1);
            i++;
        end
        check_val(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        load_prog1();

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_req",   32'(mem_req), 32'd0);
        check_val("rst_pc",    32'(pc), 32'd0);
        check_val("rst_cnt",   instr_count, 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_halt",  32'(halted), 32'd0);
        check_val("rst_flags", 32'({flag_z, flag_n}), 32'd0);
        reset = 1'b0;

        // Positive result, zero wait states
        pulse_start();
        check_val("t1_busy", 32'(busy), 32'd1);
        tick(6);
        check_val("t1_pc_br",  32'(pc), 32'd0);
        check_val("t1_cnt_br", instr_count, 32'd0);
        tick(1);
        check_val("t1_pc",   32'(pc), 32'd3);
        check_val("t1_cnt",  instr_count, 32'd1);
        check_val("t1_m11",  32'(mem[11]), 32'd2);
        check_val("t1_z",    32'(flag_z), 32'd0);
        check_val("t1_n",    32'(flag_n), 32'd0);

        // Halt via self-subtract
        tick(7);
        check_val("t2_halt", 32'(halted), 32'd1);
        check_val("t2_busy", 32'(busy), 32'd0);
        check_val("t2_pc",   32'(pc), 32'd3);
        check_val("t2_cnt",  instr_count, 32'd2);
        check_val("t2_m10",  32'(mem[10]), 32'd0);
        check_val("t2_z",    32'(flag_z), 32'd1);
        tick(3);
        check_val("t2_hold_pc", 32'(pc), 32'd3);
        check_val("t2_idle_req", 32'(mem_req), 32'd0);

        // Taken branch to 20, restarted from HALTED; count keeps going.
        // At 20: mem[30] -= mem[31] (0 - 1 = FFFF), C=8000 -> halt.
        mem[0]  = 16'd10; mem[1]  = 16'd11; mem[2]  = 16'd20;
        mem[10] = 16'd9;  mem[11] = 16'd4;
        mem[20] = 16'd31; mem[21] = 16'd30; mem[22] = 16'h8000;
        mem[30] = 16'd0;  mem[31] = 16'd1;
        pulse_start();
        tick(7);
        check_val("t3_pc",  32'(pc), 32'd20);
        check_val("t3_m11", 32'(mem[11]), 32'hFFFB);
        check_val("t3_n",   32'(flag_n), 32'd1);
        check_val("t3_z",   32'(flag_z), 32'd0);
        check_val("t3_cnt", instr_count, 32'd3);
        tick(7);
        check_val("t3_halt", 32'(halted), 32'd1);
        check_val("t3_pc2",  32'(pc), 32'd20);
        check_val("t3_m30",  32'(mem[30]), 32'hFFFF);
        check_val("t3_cnt2", instr_count, 32'd4);

        // Three wait states per access: 6*4 + 1 = 25 cycles
        pulse_reset();
        check_val("t4_rst_cnt", instr_count, 32'd0);
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        load_prog1();
        lat = 3;
        pulse_start();
        tick(24);
        check_val("t4_pc_br", 32'(pc), 32'd0);
        tick(1);
        check_val("t4_pc",  32'(pc), 32'd3);
        check_val("t4_cnt", instr_count, 32'd1);
        check_val("t4_m11", 32'(mem[11]), 32'd2);
        wait_halt("t4_halt");
        check_val("t4_cnt2", instr_count, 32'd2);
        lat = 0;

        // Single-step mode
        pulse_reset();
        load_prog1();
        step_mode = 1'b1;
        pulse_start();
        tick(7);
        check_val("t5_pc",   32'(pc), 32'd3);
        check_val("t5_busy", 32'(busy), 32'd1);
        check_val("t5_cnt",  instr_count, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("t5_noreq", 32'(mem_req), 32'd0);
        end
        check_val("t5_pc_hold", 32'(pc), 32'd3);
        pulse_step();
        check_val("t5_req", 32'(mem_req), 32'd1);
        tick(7);
        check_val("t5_halt", 32'(halted), 32'd1);
        check_val("t5_cnt2", instr_count, 32'd2);
        check_val("t5_m10",  32'(mem[10]), 32'd0);
        step_mode = 1'b0;

        // Reset in RB with ack withheld; count carried over from HALTED
        load_prog1();
        pulse_start();
        tick(4);
        ack_block = 1'b1;
        @(negedge clk);
        #1;
        check_val("t6_req",   32'(mem_req), 32'd1);
        check_val("t6_addr",  32'(mem_addr), 32'd11);
        check_val("t6_cnt",   instr_count, 32'd2);
        reset = 1'b1;
        #1;
        check_val("t6_req0",  32'(mem_req), 32'd0);
        check_val("t6_pc",    32'(pc), 32'd0);
        check_val("t6_cnt0",  instr_count, 32'd0);
        check_val("t6_busy",  32'(busy), 32'd0);
        check_val("t6_halt",  32'(halted), 32'd0);
        tick(3);
        reset = 1'b0;
        ack_block = 1'b0;
        tick(3);
        check_val("t6_m11",   32'(mem[11]), 32'd7);
        check_val("t6_idle",  32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/subleq_core.md
Name: subleq_core

Overview:
Parametrised SUBLEQ processor core that pairs the existing datapath register set (PC, operand registers, MDR) with an integrated control FSM. It talks to external memory over a req/ack handshake, so memory can have any latency. Beyond the fixed 16-bit datapath it adds configurable data and address width, halt detection, single-step mode and a retired-instruction counter. It sits between the top-level harness and the RAM model.

Parameters:
DATA_W, 16, data word width; subtraction is modulo 2^DATA_W.
ADDR_W, 16, address width; must be <= DATA_W. Operands A, B, C use their low ADDR_W bits.
RESET_PC, 0, PC value loaded on start.
COUNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  pulse; in IDLE, loads PC=RESET_PC and begins execution
step_mode  in  1  1 = pause after each retired instruction
step  in  1  pulse; releases PAUSE
mem_req  out  1  memory access request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
mem_ack  in  1  access complete
pc  out  ADDR_W  current PC
flag_z  out  1  registered: last result == 0
flag_n  out  1  registered: last result MSB
busy  out  1  1 in any state except IDLE, HALTED
halted  out  1  1 in HALTED
instr_count  out  COUNT_W  number of retired instructions

Behaviour:
- Reset (async, active-high) forces IDLE. All outputs go to 0, PC=0 and instr_count=0 immediately; an in-flight mem_req drops in the same instant.
- States: IDLE, FA, FB, FC, RA, RB, WB, BR, PAUSE, HALTED.
- IDLE: on start, PC<=RESET_PC, go to FA. start is ignored in every other state except HALTED.
- Memory states (FA, FB, FC, RA, RB, WB):
  - mem_req=1 is asserted combinationally in the state; mem_addr, mem_we and mem_wdata are held stable until ack.
  - mem_ack may be 1 in the same cycle as mem_req (zero wait states); rdata is then latched at that edge.
  - Without ack the FSM stays in the state and outputs stay unchanged.
  - mem_ack outside a memory state is ignored.
- Access sequence:
  - FA reads addr PC and latches A.
  - FB reads addr PC+1 and latches B.
  - FC reads addr PC+2 and latches C.
  - RA reads addr A and latches Ma.
  - RB reads addr B and latches Mb.
  - WB writes addr B with wdata = Mb - Ma (mod 2^DATA_W). On ack, flag_z and flag_n are updated from this result.
- PC+1 and PC+2 wrap modulo 2^ADDR_W.
- BR (1 cycle):
  - taken = flag_z | flag_n (the values just saved).
  - If taken and C[DATA_W-1]=1: go to HALTED; PC is unchanged.
  - Else if taken: PC<=C[ADDR_W-1:0].
  - Else: PC<=PC+3 (wraps modulo 2^ADDR_W).
  - instr_count increments in BR in all cases, including the halting instruction; it wraps at 2^COUNT_W.
  - Next state: PAUSE if step_mode=1, else FA.
- PAUSE: wait for step=1, then go to FA. If step_mode is cleared while in PAUSE, also go to FA next cycle.
- HALTED: hold all registers. start restarts exactly as from IDLE; instr_count is not cleared.
- Minimum instruction time is 7 cycles (6 zero-wait accesses + BR).

Decomposition:
- Package subleq_pkg holds the state enum, the state encoding width and the default widths.
- One sub-module, subleq_sub_unit: combinational Mb - Ma with zero/negative detection, parametrised by DATA_W.
- FSM, registers and memory interface stay in subleq_core.

Test Plan:
- Positive result, zero wait states. mem[0..2]={10,11,3}, mem[10]=5, mem[11]=7; pulse start. Required: mem[11]=2, flag_z=0, flag_n=0, PC=3 after 7 cycles, instr_count=1.
- Halt via self-subtract. Continue from the first test with mem[3..5]={10,10,16'hFFFF}. Required: mem[10]=0, flag_z=1, halted=1, busy=0, PC=3, instr_count=2.
- Taken branch, no halt. mem[0..2]={10,11,20}, mem[10]=9, mem[11]=4. Required: mem[11]=16'hFFFB, flag_n=1, PC=20.
- Memory wait states. Repeat the first test with ack delayed 3 cycles on every access. Required: the same results in 25 cycles, with mem_addr/mem_we/mem_wdata stable during each wait.
- Single-step mode. step_mode=1 with the two-instruction program. Required: PAUSE after the first instruction with PC=3 and busy=1; no further mem_req until step; a step pulse completes the halt.
- Reset mid-access. Assert reset during RB with ack withheld. Required: mem_req=0 in the same cycle; PC=0, instr_count=0, IDLE; no write to mem[11].
